// File: rtl/seg_scan_bank_if.sv
// rtl/seg_scan_bank_if.sv - datapath-side and display-side signal bundle for seg_scan_bank
interface seg_scan_bank_if #(
    parameter int GROUPS = 2,
    parameter int DIGITS = 4,
    parameter int VAL_W  = 16
);
    logic                       load;
    logic [GROUPS*VAL_W-1:0]    value;
    logic [GROUPS*DIGITS*4-1:0] glyph;
    logic [GROUPS-1:0]          glyph_en;
    logic [GROUPS-1:0]          lz_blank;
    logic                       lamp_test;
    logic                       busy;
    logic [GROUPS*DIGITS-1:0]   pos;
    logic [GROUPS*8-1:0]        seg;

    modport master (
        output load, value, glyph, glyph_en, lz_blank, lamp_test,
        input  busy, pos, seg
    );

    modport slave (
        input  load, value, glyph, glyph_en, lz_blank, lamp_test,
        output busy, pos, seg
    );
endinterface

// File: rtl/seg_scan_bank.sv
// rtl/seg_scan_bank.sv - multi-bank multiplexed 7-segment driver with double-dabble conversion
module seg_scan_bank #(
    parameter int GROUPS          = 2,
    parameter int DIGITS          = 4,
    parameter int VAL_W           = 16,
    parameter int SCAN_DIV        = 1000,
    parameter int POS_ACTIVE_HIGH = 1
) (
    input  logic           clk,
    input  logic           state_reset_n,
    seg_scan_bank_if.slave bus
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int NPOS  = GROUPS * DIGITS;
    localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CNT_W = $clog2(VAL_W + 1);

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int k = 0; k < n; k++) p = p * 64'd10;
        return p;
    endfunction

    localparam logic [63:0]     MAX_VAL = pow10(DIGITS) - 64'd1;
    localparam logic [NPOS-1:0] POS_OFF = (POS_ACTIVE_HIGH != 0) ? {NPOS{1'b0}} : {NPOS{1'b1}};

    // One double-dabble step: add 3 to every nibble >= 5, then shift in the next binary bit
    function automatic logic [BCD_W-1:0] dd_step(input logic [BCD_W-1:0] b, input logic bit_in);
        logic [BCD_W-1:0] a;
        for (int k = 0; k < DIGITS; k++)
            a[4*k +: 4] = (b[4*k +: 4] >= 4'd5) ? b[4*k +: 4] + 4'd3 : b[4*k +: 4];
        return {a[BCD_W-2:0], bit_in};
    endfunction

    function automatic logic [7:0] seg_pat(input logic [3:0] code);
        case (code)
            4'd0:    return 8'h3F;
            4'd1:    return 8'h06;
            4'd2:    return 8'h5B;
            4'd3:    return 8'h4F;
            4'd4:    return 8'h66;
            4'd5:    return 8'h6D;
            4'd6:    return 8'h7D;
            4'd7:    return 8'h07;
            4'd8:    return 8'h7F;
            4'd9:    return 8'h6F;
            4'd10:   return 8'h77;
            4'd11:   return 8'h39;
            4'd12:   return 8'h79;
            4'd13:   return 8'h71;
            4'd14:   return 8'h40;
            default: return 8'h00;
        endcase
    endfunction

    logic                 r_busy;
    logic [CNT_W-1:0]     r_cnt;
    logic [VAL_W-1:0]     r_bin  [GROUPS];
    logic [BCD_W-1:0]     r_bcd  [GROUPS];
    logic [BCD_W-1:0]     r_gsh  [GROUPS];
    logic [BCD_W-1:0]     r_disp [GROUPS];
    logic [GROUPS-1:0]    r_gen;
    logic [GROUPS-1:0]    r_ovf;
    logic [GROUPS-1:0]    r_num;
    logic [PRE_W-1:0]     r_pre;
    logic [IDX_W-1:0]     r_idx;
    logic [NPOS-1:0]      r_pos;
    logic [GROUPS*8-1:0]  r_seg;
    logic [NPOS-1:0]      w_pos_nxt;
    logic [GROUPS*8-1:0]  w_seg_nxt;

    // Capture on load, run VAL_W shifts on all banks, then publish every bank in one edge
    always_ff @(posedge clk or negedge state_reset_n) begin
        if (!state_reset_n) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_gen  <= '0;
            r_ovf  <= '0;
            r_num  <= '0;
            for (int g = 0; g < GROUPS; g++) begin
                r_bin[g]  <= '0;
                r_bcd[g]  <= '0;
                r_gsh[g]  <= '0;
                r_disp[g] <= '0;
            end
        end else if (!r_busy) begin
            if (bus.load) begin
                r_busy <= 1'b1;
                r_cnt  <= '0;
                r_gen  <= bus.glyph_en;
                for (int g = 0; g < GROUPS; g++) begin
                    r_bin[g] <= bus.value[g*VAL_W +: VAL_W];
                    r_bcd[g] <= '0;
                    r_gsh[g] <= bus.glyph[g*BCD_W +: BCD_W];
                    r_ovf[g] <= 64'(bus.value[g*VAL_W +: VAL_W]) > MAX_VAL;
                end
            end
        end else if (r_cnt != CNT_W'(VAL_W)) begin
            r_cnt <= r_cnt + CNT_W'(1);
            for (int g = 0; g < GROUPS; g++) begin
                r_bcd[g] <= dd_step(r_bcd[g], r_bin[g][VAL_W-1]);
                r_bin[g] <= r_bin[g] << 1;
            end
        end else begin
            r_busy <= 1'b0;
            r_num  <= ~r_gen & ~r_ovf;
            for (int g = 0; g < GROUPS; g++) begin
                if (r_gen[g])
                    r_disp[g] <= r_gsh[g];
                else if (r_ovf[g])
                    r_disp[g] <= {DIGITS{4'd14}};
                else
                    r_disp[g] <= r_bcd[g];
            end
        end
    end

    // Prescaler and shared digit index, independent of conversion and lamp test
    always_ff @(posedge clk or negedge state_reset_n) begin
        if (!state_reset_n) begin
            r_pre <= '0;
            r_idx <= '0;
        end else if (r_pre == PRE_W'(SCAN_DIV - 1)) begin
            r_pre <= '0;
            r_idx <= (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
        end else begin
            r_pre <= r_pre + PRE_W'(1);
        end
    end

    // Next pos/seg from the current index, with live leading-zero blanking and lamp override
    always_comb begin
        logic [3:0] w_code;
        logic       w_zero_hi;
        w_pos_nxt = '0;
        w_seg_nxt = '0;
        w_code    = '0;
        w_zero_hi = 1'b0;
        for (int g = 0; g < GROUPS; g++) begin
            w_code    = r_disp[g][4*r_idx +: 4];
            w_zero_hi = 1'b1;
            for (int d = 0; d < DIGITS; d++)
                if (d >= int'(r_idx) && r_disp[g][4*d +: 4] != 4'd0) w_zero_hi = 1'b0;
            if (r_num[g] && bus.lz_blank[g] && r_idx != '0 && w_zero_hi) w_code = 4'd15;
            w_seg_nxt[8*g +: 8] = bus.lamp_test ? 8'hFF : seg_pat(w_code);
            for (int d = 0; d < DIGITS; d++)
                w_pos_nxt[g*DIGITS + d] = bus.lamp_test || (int'(r_idx) == d);
        end
        if (POS_ACTIVE_HIGH == 0) w_pos_nxt = ~w_pos_nxt;
    end

    // pos and seg registered together so they never skew
    always_ff @(posedge clk or negedge state_reset_n) begin
        if (!state_reset_n) begin
            r_pos <= POS_OFF;
            r_seg <= '0;
        end else begin
            r_pos <= w_pos_nxt;
            r_seg <= w_seg_nxt;
        end
    end

    assign bus.busy = r_busy;
    assign bus.pos  = r_pos;
    assign bus.seg  = r_seg;
endmodule

// File: tb/tb_seg_scan_bank.sv
// tb/tb_seg_scan_bank.sv - randomized self-checking bench for seg_scan_bank
module tb_seg_scan_bank;
    localparam int G  = 2;
    localparam int D  = 4;
    localparam int W  = 16;
    localparam int SD = 4;

    logic clk = 1'b0;
    logic state_reset_n = 1'b1;
    always #5 clk = ~clk;

    seg_scan_bank_if #(.GROUPS(G), .DIGITS(D), .VAL_W(W)) bus ();
    seg_scan_bank #(.GROUPS(G), .DIGITS(D), .VAL_W(W), .SCAN_DIV(SD), .POS_ACTIVE_HIGH(1)) dut (
        .clk(clk), .state_reset_n(state_reset_n), .bus(bus)
    );

    seg_scan_bank_if #(.GROUPS(1), .DIGITS(3), .VAL_W(10)) bus2 ();
    seg_scan_bank #(.GROUPS(1), .DIGITS(3), .VAL_W(10), .SCAN_DIV(1), .POS_ACTIVE_HIGH(0)) dut2 (
        .clk(clk), .state_reset_n(state_reset_n), .bus(bus2)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0]  pat_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                  8'h7F, 8'h6F, 8'h77, 8'h39, 8'h79, 8'h71, 8'h40, 8'h00};
    logic [15:0] mdl_val [G];
    logic [15:0] mdl_gly [G];
    logic [1:0]  mdl_gen;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] model_seg(input int dig, input int val, input logic gen,
                                             input logic [15:0] gly, input logic lz, input int ndig);
        int p10, maxv;
        logic [3:0] code;
        p10 = 1;
        for (int k = 0; k < dig; k++) p10 *= 10;
        maxv = 1;
        for (int k = 0; k < ndig; k++) maxv *= 10;
        maxv -= 1;
        if (gen)                                code = gly[4*dig +: 4];
        else if (val > maxv)                    code = 4'd14;
        else if (lz && dig > 0 && val < p10)    code = 4'd15;
        else                                    code = 4'((val / p10) % 10);
        return pat_tab[code];
    endfunction

    function automatic logic [15:0] pick_val();
        case ($urandom_range(0, 5))
            0:       return 16'd0;
            1:       return 16'd9999;
            2:       return 16'd10000;
            3:       return 16'($urandom_range(0, 9));
            4:       return 16'($urandom);
            default: return 16'($urandom_range(0, 9999));
        endcase
    endfunction

    task automatic do_load(input logic [15:0] v0, input logic [15:0] v1, input logic [1:0] gen,
                           input logic [31:0] gly, input logic [1:0] lz);
        @(negedge clk);
        bus.value    = {v1, v0};
        bus.glyph_en = gen;
        bus.glyph    = gly;
        bus.lz_blank = lz;
        bus.load     = 1'b1;
        mdl_val[0] = v0;
        mdl_val[1] = v1;
        mdl_gen    = gen;
        mdl_gly[0] = gly[15:0];
        mdl_gly[1] = gly[31:16];
        @(negedge clk);
        bus.load = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (bus.busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_idle"}, 64'(n < 100), 64'd1);
        @(negedge clk);
    endtask

    task automatic check_disp(input string tag);
        int n = 0;
        logic [3:0]     e0;
        logic [G*D-1:0] ep;
        while (bus.pos[D-1:0] == 4'b0001 && n < 50) begin @(negedge clk); n++; end
        while (bus.pos[D-1:0] != 4'b0001 && n < 50) begin @(negedge clk); n++; end
        chk({tag, "_sync"}, 64'(n < 50), 64'd1);
        for (int c = 0; c < D*SD; c++) begin
            if (c % SD == 0) begin
                e0 = 4'b0001 << (c / SD);
                ep = {e0, e0};
                chk($sformatf("%s_pos_d%0d", tag, c / SD), 64'(bus.pos), 64'(ep));
                for (int g = 0; g < G; g++)
                    chk($sformatf("%s_seg_b%0d_d%0d", tag, g, c / SD), 64'(bus.seg[8*g +: 8]),
                        64'(model_seg(c / SD, int'(mdl_val[g]), mdl_gen[g], mdl_gly[g], bus.lz_blank[g], D)));
            end
            @(negedge clk);
        end
    endtask

    task automatic check_disp2(input string tag, input int val);
        int n = 0;
        logic [2:0] ep;
        while (bus2.pos != 3'b110 && n < 20) begin @(negedge clk); n++; end
        chk({tag, "_sync"}, 64'(n < 20), 64'd1);
        for (int d = 0; d < 3; d++) begin
            ep = ~(3'b001 << d);
            chk($sformatf("%s_pos_d%0d", tag, d), 64'(bus2.pos), 64'(ep));
            chk($sformatf("%s_seg_d%0d", tag, d), 64'(bus2.seg), 64'(model_seg(d, val, 1'b0, 16'd0, 1'b0, 3)));
            @(negedge clk);
        end
    endtask

    task automatic load2(input logic [9:0] v);
        int n = 0;
        @(negedge clk);
        bus2.value = v;
        bus2.load  = 1'b1;
        @(negedge clk);
        bus2.load = 1'b0;
        while (bus2.busy && n < 50) begin @(negedge clk); n++; end
        chk("dut2_idle", 64'(n < 50), 64'd1);
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]     e0;
        logic [G*D-1:0] ep;
        logic [2:0]     e2;
        int n;
        bus.load = 1'b0; bus.value = '0; bus.glyph = '0; bus.glyph_en = '0;
        bus.lz_blank = '0; bus.lamp_test = 1'b0;
        bus2.load = 1'b0; bus2.value = '0; bus2.glyph = '0; bus2.glyph_en = '0;
        bus2.lz_blank = '0; bus2.lamp_test = 1'b0;

        // reset state
        #2 state_reset_n = 1'b0;
        #1;
        chk("rst_pos", 64'(bus.pos), 64'd0);
        chk("rst_seg", 64'(bus.seg), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_pos2", 64'(bus2.pos), 64'h7);
        @(negedge clk);
        @(negedge clk);
        state_reset_n = 1'b1;

        // scan timing after release
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            e0 = 4'b0001 << (((k - 1) / SD) % D);
            ep = {e0, e0};
            e2 = ~(3'b001 << ((k - 1) % 3));
            chk($sformatf("scan_pos_k%0d", k), 64'(bus.pos), 64'(ep));
            chk($sformatf("scan_seg_k%0d", k), 64'(bus.seg[7:0]), 64'h3F);
            chk($sformatf("scan_pos2_k%0d", k), 64'(bus2.pos), 64'(e2));
        end
        chk("scan_busy", 64'(bus.busy), 64'd0);

        // busy length, ignored second load
        do_load(16'd1234, 16'd56, 2'b00, 32'd0, 2'b00);
        n = 0;
        while (bus.busy && n < 40) begin
            n++;
            if (n == 5) begin
                bus.value = 32'hFFFF_FFFF;
                bus.glyph_en = 2'b11;
            end
            bus.load = (n == 5);
            @(negedge clk);
        end
        bus.load = 1'b0;
        chk("busy_len", 64'(n), 64'd17);
        @(negedge clk);
        check_disp("conv1234");

        // leading-zero blanking, live
        do_load(16'd305, 16'd7, 2'b00, 32'd0, 2'b11);
        wait_idle("lz7");
        check_disp("lz7");
        do_load(16'd1000, 16'd0, 2'b00, 32'd0, 2'b10);
        wait_idle("lz0");
        check_disp("lz0");
        bus.lz_blank = 2'b01;
        check_disp("lz_live");

        // overflow and glyph mode
        do_load(16'd9999, 16'd10000, 2'b00, 32'd0, 2'b00);
        wait_idle("ovf");
        check_disp("ovf");
        do_load(16'd0, 16'd42, 2'b01, {16'h0000, 4'd10, 4'd11, 4'd12, 4'd15}, 2'b11);
        wait_idle("glyph");
        check_disp("glyph");

        // lamp test mid-conversion
        do_load(16'd8080, 16'd9, 2'b00, 32'd0, 2'b10);
        @(negedge clk);
        bus.lamp_test = 1'b1;
        @(negedge clk);
        bus.lamp_test = 1'b0;
        chk("lamp_pos", 64'(bus.pos), 64'hFF);
        chk("lamp_seg", 64'(bus.seg), 64'hFFFF);
        chk("lamp_busy", 64'(bus.busy), 64'd1);
        @(negedge clk);
        chk("lamp_release", 64'(bus.pos == 8'hFF), 64'd0);
        wait_idle("lamp");
        check_disp("lamp");

        // randomized transactions
        for (int t = 0; t < 25; t++) begin
            do_load(pick_val(), pick_val(), 2'($urandom), $urandom, 2'($urandom));
            wait_idle($sformatf("rnd%0d", t));
            check_disp($sformatf("rnd%0d", t));
        end

        // small-bank instance: 999 fits, 1000 overflows, inverted pos, SCAN_DIV=1
        load2(10'd999);
        check_disp2("d2_999", 999);
        load2(10'd1000);
        check_disp2("d2_1000", 1000);
        load2(10'd0);
        check_disp2("d2_0", 0);

        // reset mid-conversion
        do_load(16'd4321, 16'd8765, 2'b00, 32'd0, 2'b00);
        @(negedge clk);
        @(negedge clk);
        state_reset_n = 1'b0;
        #1;
        chk("arst_pos", 64'(bus.pos), 64'd0);
        chk("arst_busy", 64'(bus.busy), 64'd0);
        chk("arst_seg", 64'(bus.seg), 64'd0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        state_reset_n = 1'b1;
        mdl_val[0] = 16'd0; mdl_val[1] = 16'd0;
        mdl_gly[0] = 16'd0; mdl_gly[1] = 16'd0;
        mdl_gen = 2'b11;
        @(negedge clk);
        chk("arst_busy_after", 64'(bus.busy), 64'd0);
        check_disp("arst_disp");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
